// File: rtl/upload_proto_pkg.sv
// upload_proto_pkg: framing constants and checksum shared by the upload packer and parser
package upload_proto_pkg;
  localparam logic [7:0] FRAME_HEADER_H = 8'hAA;
  localparam logic [7:0] FRAME_HEADER_L = 8'h44;
  localparam int MAX_LEN = 255;
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction
endpackage

// File: rtl/frame_buf_ram.sv
// frame_buf_ram: 256x8 simple dual-port payload buffer, synchronous write and read
module frame_buf_ram (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic       re,
  input  logic [7:0] raddr,
  output logic [7:0] rdata
);
  logic [7:0] mem [256];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // read register doubles as the output data register, so it is held when re is low
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= 8'd0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/upload_frame_parser.sv
// upload_frame_parser: locates AA 44 framed uploads, checks the checksum, releases payload of good frames
module upload_frame_parser
  import upload_proto_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic [7:0] out_source,
  output logic [7:0] out_len,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       frame_ok,
  output logic       csum_err,
  output logic       len_err
);
  typedef enum logic [2:0] {HUNT_H1, HUNT_H2, GET_SRC, GET_LEN_H, GET_LEN_L, GET_DATA, GET_CSUM, EMIT} state_t;
  state_t state, next;
  logic [7:0] csum, len_h, wr_idx, rd_idx;
  logic take, beat, len_bad, csum_ok, ram_re;
  assign take      = in_valid && in_ready;
  assign out_valid = state == EMIT;
  assign beat      = out_valid && out_ready;
  assign out_last  = out_valid && (rd_idx == out_len - 8'd1);
  assign len_bad   = len_h != 8'd0 || in_data == 8'd0 || int'(in_data) > MAX_LEN;
  assign csum_ok   = in_data == csum;
  // buffer[0] is fetched while the checksum byte is accepted; later reads prefetch the next beat
  assign ram_re    = (take && state == GET_CSUM && csum_ok) || (beat && !out_last);
  frame_buf_ram u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (take && state == GET_DATA),
    .waddr (wr_idx),
    .wdata (in_data),
    .re    (ram_re),
    .raddr (state == EMIT ? rd_idx + 8'd1 : 8'd0),
    .rdata (out_data)
  );
  always_comb begin
    next = state;
    case (state)
      HUNT_H1:   if (take && in_data == FRAME_HEADER_H) next = HUNT_H2;
      HUNT_H2:   if (take) next = in_data == FRAME_HEADER_L ? GET_SRC : in_data == FRAME_HEADER_H ? HUNT_H2 : HUNT_H1;
      GET_SRC:   if (take) next = GET_LEN_H;
      GET_LEN_H: if (take) next = GET_LEN_L;
      GET_LEN_L: if (take) next = len_bad ? HUNT_H1 : GET_DATA;
      GET_DATA:  if (take && wr_idx == out_len - 8'd1) next = GET_CSUM;
      GET_CSUM:  if (take) next = csum_ok ? EMIT : HUNT_H1;
      EMIT:      if (beat && out_last) next = HUNT_H1;
      default:   next = HUNT_H1;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= HUNT_H1;
      in_ready   <= 1'b0;
      frame_ok   <= 1'b0;
      csum_err   <= 1'b0;
      len_err    <= 1'b0;
      csum       <= 8'd0;
      len_h      <= 8'd0;
      wr_idx     <= 8'd0;
      rd_idx     <= 8'd0;
      out_source <= 8'd0;
      out_len    <= 8'd0;
    end else begin
      state    <= next;
      in_ready <= next != EMIT;
      frame_ok <= take && state == GET_CSUM && csum_ok;
      csum_err <= take && state == GET_CSUM && !csum_ok;
      len_err  <= take && state == GET_LEN_L && len_bad;
      // a header byte restarts the running sum, including a repeated AA while resyncing
      if (take)
        csum <= (state == HUNT_H1 || (state == HUNT_H2 && in_data == FRAME_HEADER_H)) ? in_data : csum_add(csum, in_data);
      if (take && state == GET_SRC) out_source <= in_data;
      if (take && state == GET_LEN_H) len_h <= in_data;
      if (take && state == GET_LEN_L && !len_bad) begin
        out_len <= in_data;
        wr_idx  <= 8'd0;
      end
      if (take && state == GET_DATA) wr_idx <= wr_idx + 8'd1;
      if (take && state == GET_CSUM) rd_idx <= 8'd0;
      else if (beat) rd_idx <= rd_idx + 8'd1;
    end
endmodule

// File: tb/tb_upload_frame_parser.sv
// tb_upload_frame_parser: directed frames with a beat scoreboard and an independent output monitor
module tb_upload_frame_parser;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_last, frame_ok, csum_err, len_err;
  logic [7:0] out_data, out_source, out_len;
  always #5 clk = ~clk;
  upload_frame_parser dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_source(out_source), .out_len(out_len), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .frame_ok(frame_ok), .csum_err(csum_err), .len_err(len_err)
  );
  typedef struct packed {logic [7:0] d; logic [7:0] s; logic [7:0] l; logic last;} beat_t;
  beat_t q[$];
  beat_t e;
  int compared = 0, mismatched = 0, ok_seen = 0;
  logic toggle = 1'b0, hold_pending = 1'b0;
  logic [8:0] held;
  logic [7:0] pay [256];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    out_ready = toggle ? ~out_ready : 1'b1;
  end
  always @(negedge clk)
    if (!rst_n) hold_pending = 1'b0;
    else begin
      if (frame_ok) ok_seen++;
      if (hold_pending && out_valid) chk("hold", {out_data, out_last}, held);
      if (out_valid) chk("in_ready_emit", in_ready, 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_beat: got %0h expected none", out_data);
        end else begin
          e = q.pop_front();
          chk("beat", {out_data, out_source, out_len, out_last}, e);
        end
      end
      hold_pending = out_valid && !out_ready;
      held = {out_data, out_last};
    end
  task automatic send(input logic [7:0] b);
    int n = 0;
    in_data = b;
    in_valid = 1'b1;
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(negedge clk);
  endtask
  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
  endtask
  task automatic send_frame(input logic [7:0] src, input logic [7:0] len, input logic bad);
    logic [7:0] sum;
    sum = 8'hAA + 8'h44 + src + len;
    for (int i = 0; i < len; i++) begin
      sum = sum + pay[i];
      if (!bad) q.push_back({pay[i], src, len, i == len - 1});
    end
    send(8'hAA); send(8'h44); send(src); send(8'h00); send(len);
    for (int i = 0; i < len; i++) send(pay[i]);
    send(bad ? sum + 8'd1 : sum);
    in_valid = 1'b0;
    chk("frame_ok", frame_ok, !bad);
    chk("csum_err", csum_err, bad);
    chk("first_valid", out_valid, !bad);
    if (!bad) drain();
  endtask
  task automatic set_small();
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
  endtask
  initial begin
    #1 chk("reset_outputs", {in_ready, out_data, out_source, out_len, out_valid, out_last, frame_ok, csum_err, len_err}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_small();
    send_frame(8'h01, 8'd3, 1'b0);
    send_frame(8'h01, 8'd3, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("no_out_after_csum_err", out_valid, 0);
    end
    send_frame(8'h01, 8'd3, 1'b0);
    q.push_back({8'h7E, 8'h02, 8'h01, 1'b1});
    send(8'h00); send(8'hAA); send(8'hAA); send(8'h44); send(8'h02);
    send(8'h00); send(8'h01); send(8'h7E); send(8'h6F);
    in_valid = 1'b0;
    chk("resync_frame_ok", frame_ok, 1);
    drain();
    send(8'hAA); send(8'h44); send(8'h05); send(8'h01); send(8'h00);
    in_valid = 1'b0;
    chk("len_err_len_h", len_err, 1);
    @(negedge clk);
    chk("len_err_pulse_end", len_err, 0);
    send(8'hAA); send(8'h44); send(8'h05); send(8'h00); send(8'h00);
    in_valid = 1'b0;
    chk("len_err_zero", len_err, 1);
    set_small();
    send_frame(8'h01, 8'd3, 1'b0);
    for (int i = 0; i < 255; i++) pay[i] = 8'(i);
    toggle = 1'b1;
    send_frame(8'h07, 8'd255, 1'b0);
    toggle = 1'b0;
    send(8'hAA); send(8'h44); send(8'h03); send(8'h00); send(8'h04); send(8'hAA); send(8'hBB);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1 chk("reset_mid_frame", {in_ready, out_data, out_source, out_len, out_valid, out_last, frame_ok, csum_err, len_err}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_small();
    send_frame(8'h01, 8'd3, 1'b0);
    repeat (3) @(negedge clk);
    chk("frame_ok_count", ok_seen, 6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
